// File: rtl/mtd_fifo_pkg.sv
// Shared helpers for the MTD synchronous FIFO: level/pointer width function,
// parameter legality checks and the packed status structures.
package mtd_fifo_pkg;

    // Pointers and the level counter share this width: address bits plus a wrap bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(
        input int width,
        input int depth,
        input int afull_lvl,
        input int aempty_lvl
    );
        return (width >= 1) && (depth >= 4) && is_pow2(depth)
            && (afull_lvl >= 1) && (afull_lvl <= depth)
            && (aempty_lvl >= 0) && (aempty_lvl <= depth - 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } flags_t;

    typedef struct packed {
        logic ovf;
        logic udf;
    } err_t;

endpackage

// File: rtl/mtd_fifo_ram.sv
// Simple dual-port register array for the MTD FIFO: one synchronous write port and
// one read port, registered by default or asynchronous when MTD_FIFO_FWFT_EN is defined.
module mtd_fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // NOTE: the storage array has no reset; validity is tracked by the pointers alone,
    // which keeps the array mappable onto reset-free flops or distributed RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef MTD_FIFO_FWFT_EN
    assign rdata = mem[raddr];

    logic unused_ctrl;
    assign unused_ctrl = rst ^ re;
`else
    // A simultaneous write to the same entry lands after this read samples the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/mtd_sync_fifo.sv
// Single-clock parametrised FIFO with level count, threshold flags and sticky errors.
// Define MTD_FIFO_FWFT_EN for first-word-fall-through reads instead of registered RD.
module mtd_sync_fifo
    import mtd_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2,
    parameter int LW         = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wd,
    input  logic             we,
    input  logic             re,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [LW-1:0]    level,
    output logic             ovf,
    output logic             udf
);

    localparam int AW = LW - 1;

    typedef logic [LW-1:0] ptr_t;

    if (!params_ok(WIDTH, DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
        $error("mtd_sync_fifo: illegal WIDTH/DEPTH/AFULL_LVL/AEMPTY_LVL combination");
    end

    ptr_t   wptr_q;
    ptr_t   rptr_q;
    ptr_t   level_q;
    err_t   err_q;
    flags_t flags;

    logic wr_acc;
    logic rd_acc;

    assign flags.full   = (level_q == ptr_t'(DEPTH));
    assign flags.empty  = (level_q == '0);
    assign flags.afull  = (level_q >= ptr_t'(AFULL_LVL));
    assign flags.aempty = (level_q <= ptr_t'(AEMPTY_LVL));

    // A read frees the slot the write needs, so a full FIFO still accepts a write alongside a pop.
    assign rd_acc = re & ~flags.empty;
    assign wr_acc = we & (~flags.full | rd_acc);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            err_q   <= '0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + ptr_t'(1);
            end
            if (rd_acc) begin
                rptr_q <= rptr_q + ptr_t'(1);
            end
            level_q <= level_q + ptr_t'(wr_acc) - ptr_t'(rd_acc);

            // A fresh error outranks a clear request in the same cycle.
            if (we && !wr_acc) begin
                err_q.ovf <= 1'b1;
            end else if (clr_err) begin
                err_q.ovf <= 1'b0;
            end
            if (re && !rd_acc) begin
                err_q.udf <= 1'b1;
            end else if (clr_err) begin
                err_q.udf <= 1'b0;
            end
        end
    end

    mtd_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wptr_q[AW-1:0]),
        .wdata (wd),
        .re    (rd_acc),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rd)
    );

    assign full   = flags.full;
    assign empty  = flags.empty;
    assign afull  = flags.afull;
    assign aempty = flags.aempty;
    assign level  = level_q;
    assign ovf    = err_q.ovf;
    assign udf    = err_q.udf;

endmodule

// File: tb/tb_mtd_sync_fifo.sv
// Scoreboard bench for mtd_sync_fifo: a queue-based reference model predicts status and
// popped data per cycle; a separate monitor compares them against the DUT outputs.
`timescale 1ns/1ps

module tb_mtd_sync_fifo;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 16;
    localparam int AFULL_LVL  = 12;
    localparam int AEMPTY_LVL = 2;
    localparam int LW         = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] wd = '0;
    logic             we = 1'b0;
    logic             re = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] rd;
    logic             full, empty, afull, aempty, ovf, udf;
    logic [LW-1:0]    level;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int level;
        bit full;
        bit empty;
        bit afull;
        bit aempty;
        bit ovf;
        bit udf;
        bit pop;
        int front;
    } exp_t;

    exp_t stat_q[$];
    int   data_q[$];

    int model_q[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    always #5 clk = ~clk;

    mtd_sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFULL_LVL),
        .AEMPTY_LVL (AEMPTY_LVL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wd      (wd),
        .we      (we),
        .re      (re),
        .clr_err (clr_err),
        .rd      (rd),
        .full    (full),
        .empty   (empty),
        .afull   (afull),
        .aempty  (aempty),
        .level   (level),
        .ovf     (ovf),
        .udf     (udf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and predict the state the FIFO holds after the next edge.
    task automatic step(input bit r, input bit w, input bit rr, input int d, input bit c);
        exp_t e;
        bit   rd_ok;
        bit   wr_ok;
        @(negedge clk);
        rst     = r;
        we      = w;
        re      = rr;
        wd      = d[WIDTH-1:0];
        clr_err = c;
        e.pop   = 1'b0;
        if (r) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            e.pop = 1'b1;
            data_q.push_back(0);
        end else begin
            rd_ok = rr && (model_q.size() > 0);
            wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                e.pop = 1'b1;
                data_q.push_back(model_q.pop_front());
            end
            if (wr_ok) begin
                model_q.push_back(d & 16'hFFFF);
            end
            if (w && !wr_ok) m_ovf = 1'b1;
            else if (c)      m_ovf = 1'b0;
            if (rr && !rd_ok) m_udf = 1'b1;
            else if (c)       m_udf = 1'b0;
        end
        e.level  = model_q.size();
        e.full   = (e.level == DEPTH);
        e.empty  = (e.level == 0);
        e.afull  = (e.level >= AFULL_LVL);
        e.aempty = (e.level <= AEMPTY_LVL);
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        e.front  = (model_q.size() > 0) ? model_q[0] : 0;
        stat_q.push_back(e);
    endtask

    // Monitor: after every edge, pop one prediction and compare the DUT against it.
    initial begin : monitor
        exp_t e;
        int   last_rd;
        last_rd = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stat_q.size() > 0) begin
                e = stat_q.pop_front();
                check("level",  level,  e.level);
                check("full",   full,   e.full);
                check("empty",  empty,  e.empty);
                check("afull",  afull,  e.afull);
                check("aempty", aempty, e.aempty);
                check("ovf",    ovf,    e.ovf);
                check("udf",    udf,    e.udf);
                if (e.pop && data_q.size() > 0) begin
                    last_rd = data_q.pop_front();
                end
`ifdef MTD_FIFO_FWFT_EN
                if (!e.empty) begin
                    check("rd_fwft", rd, e.front);
                end
`else
                check("rd", rd, last_rd);
`endif
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int mode;
        int pw;
        bit w;
        bit r;
        bit x;
        bit c;

        // Reset, then fill: AFULL after 12th write, FULL after 16th.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) step(0, 1, 0, i, 0);

        // Overflow from full, then drain in order and underflow.
        step(0, 1, 0, 16'hDEAD, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // Error set and clear in the same cycle: error wins.
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);

        // Empty with WE=RE=1: read rejected, write accepted.
        step(0, 1, 1, 16'h0055, 0);
        step(0, 0, 1, 0, 1);

        // Full with simultaneous push/pop for 40 cycles, then drain.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 16'h0100 + i, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 1, 16'h0200 + i, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);

        // Reset mid-stream discards data; next read underflows.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0300 + i, 0);
        step(1, 1, 1, 16'h0399, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // Randomised bursts with varying write/read bias.
        for (int b = 0; b < 60; b++) begin
            mode = $urandom_range(0, 2);
            pw   = (mode == 0) ? 80 : (mode == 1) ? 20 : 50;
            for (int i = 0; i < 25; i++) begin
                w = ($urandom_range(0, 99) < pw);
                r = ($urandom_range(0, 99) < (100 - pw));
                x = ($urandom_range(0, 299) == 0);
                c = ($urandom_range(0, 15) == 0);
                step(x, w, r, $urandom_range(0, 16'hFFFF), c);
            end
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        check("stat_q_drained", stat_q.size(), 0);
        check("data_q_drained", data_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
